// File: rtl/d_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | d_debounce : level debouncer with rise/fall/glitch strobes. Optional     |
// | 2-flop input synchronizer enabled by defining D_DEBOUNCE_SYNC_EN.        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module d_debounce #(
    parameter int STABLE = 4,
    parameter int CNT_W  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic glitch,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_q;
    logic             rise_q;
    logic             fall_q;
    logic             glitch_q;
    logic             busy_q;
    logic             d_s;

`ifdef D_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign d_s = sync_q[1];
`else
    assign d_s = d;
`endif

    // Strobes default low each cycle so every event yields exactly one pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            q_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (d_s != q_q) begin
                        state_q <= ST_CHECK;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    // A revert on the final count still wins over the commit.
                    if (d_s == q_q) begin
                        state_q  <= ST_STABLE;
                        cnt_q    <= '0;
                        glitch_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        q_q     <= d_s;
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                        rise_q  <= d_s;
                        fall_q  <= ~d_s;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = q_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_d_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_d_debounce : directed + random bench for d_debounce with a run-length |
// | reference model.  Revision : 1.0                                         |
// +--------------------------------------------------------------------------+
module tb_d_debounce;

    localparam int STABLE = 4;
    localparam int CNT_W  = 3;
`ifdef D_DEBOUNCE_SYNC_EN
    localparam int LAT = STABLE + 2;
`else
    localparam int LAT = STABLE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d   = 1'b0;
    logic q, rise, fall, glitch, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: length of the current run of samples that differ
    // from the committed level, plus a delay line standing in for the
    // optional synchronizer.
    logic     m_q, m_rise, m_fall, m_glitch;
    int       m_run;
    logic [1:0] m_dly;

    d_debounce #(.STABLE(STABLE), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .q      (q),
        .rise   (rise),
        .fall   (fall),
        .glitch (glitch),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
        m_run = 0; m_dly = 2'b00;
    endtask

    task automatic model_edge(input logic dv);
        logic s;
`ifdef D_DEBOUNCE_SYNC_EN
        s     = m_dly[1];
        m_dly = {m_dly[0], dv};
`else
        s = dv;
`endif
        m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
        if (s != m_q) begin
            m_run++;
            if (m_run == STABLE) begin
                m_q    = s;
                m_rise = s;
                m_fall = ~s;
                m_run  = 0;
            end
        end else begin
            if (m_run > 0) m_glitch = 1'b1;
            m_run = 0;
        end
    endtask

    task automatic check_all();
        check("q",      q,      m_q);
        check("rise",   rise,   m_rise);
        check("fall",   fall,   m_fall);
        check("glitch", glitch, m_glitch);
        check("busy",   busy,   m_run > 0);
    endtask

    task automatic step(input logic dv);
        d = dv;
        @(posedge clk);
        model_edge(dv);
        #1;
        check_all();
    endtask

    // Holds d at 1 and returns the number of edges until rise is seen.
    task automatic measure_rise(input int maxc, output int n, output int glitches);
        n = -1;
        glitches = 0;
        for (int i = 1; i <= maxc; i++) begin
            step(1'b1);
            if (glitch) glitches++;
            if (rise && n < 0) n = i;
        end
    endtask

    initial begin
        int n, g, rises, glits;
        model_reset();
        rst = 1'b0;
        #12;
        check_all();
        rst = 1'b1;

        // Clean rise with latency measurement.
        for (int i = 0; i < 5 + LAT; i++) step(1'b0);
        measure_rise(LAT + 3, n, g);
        check_int("rise_latency", n, LAT);
        check("q_after_rise", q, 1'b1);

        // Fall back to 0.
        for (int i = 0; i < LAT + 2; i++) step(1'b0);
        check("q_after_fall", q, 1'b0);

        // Short pulses: 2-cycle and 3-cycle (revert at commit boundary).
        for (int len = 2; len <= 4; len++) begin
            rises = 0; glits = 0;
            for (int i = 0; i < len; i++) begin
                step(1'b1);
                if (rise) rises++;
                if (glitch) glits++;
            end
            for (int i = 0; i < LAT + 4; i++) begin
                step(1'b0);
                if (rise) rises++;
                if (glitch) glits++;
            end
            check_int($sformatf("pulse%0d_rise", len), rises, (len >= STABLE) ? 1 : 0);
            check_int($sformatf("pulse%0d_glitch", len), glits, (len >= STABLE) ? 0 : 1);
        end

        // Reset mid-count: two counted cycles, then a one-cycle reset pulse.
        for (int i = 0; i < LAT - STABLE + 2; i++) step(1'b1);
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        measure_rise(LAT + 3, n, g);
        check_int("rst_rise_latency", n, LAT);
        check_int("rst_no_glitch", g, 0);

        // Back-to-back: opposite change immediately after a commit.
        for (int i = 0; i < LAT + 3; i++) step(1'b0);
        for (int i = 0; i < LAT + 3; i++) step(1'b1);

        // Randomised bursts of varying length.
        for (int b = 0; b < 150; b++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, STABLE + 3));
            for (int i = 0; i < len; i++) step(lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/d_debounce.md
# d_debounce

Level debouncer and edge detector that consumes the single-bit output of the `d_ff` register stage. It accepts a raw, possibly bouncy bit `d` and promotes it to a clean level `q` only after the bit has held a new value for `STABLE` consecutive clock cycles. It also produces one-cycle `rise` and `fall` strobes on each committed transition, and a `glitch` strobe whenever a candidate change is rejected.

## Interface
- `STABLE`, default 4: consecutive cycles a new input value must persist before `q` follows it. Legal range is 2 .. 2^CNT_W−1.
- `CNT_W`, default 3: width of the stability counter.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. The clock is `clk`; asserting `rst` low clears all state immediately.
- `d` input 1: raw input bit, driven from the `d_ff` output `q`.
- `q` output 1: debounced level, registered.
- `rise` output 1: one-cycle strobe, high in the first cycle `q` reads 1 after being 0.
- `fall` output 1: one-cycle strobe, high in the first cycle `q` reads 0 after being 1.
- `glitch` output 1: one-cycle strobe, high for one cycle after a candidate change is abandoned before commit.
- `busy` output 1: high while a candidate change is being counted (state CHECK).

## Operation
- Internal sample `d_s`:
  - Without `D_DEBOUNCE_SYNC_EN`, `d_s` is `d` directly.
  - With `D_DEBOUNCE_SYNC_EN`, `d_s` is the output of a 2-flop synchronizer.
- State machine has two states, STABLE and CHECK. Counter `cnt` is `CNT_W` bits wide.
- STABLE (`cnt` = 0):
  - If `d_s` ≠ `q`: go to CHECK, `cnt` ← 1.
  - Otherwise: stay.
- CHECK:
  - If `d_s` = `q`: go to STABLE, `cnt` ← 0, `glitch` ← 1 for the next cycle. `q` is unchanged.
  - Else if `cnt` = `STABLE`−1: `q` ← `d_s`. Go to STABLE, `cnt` ← 0. Next cycle `rise` ← `d_s` and `fall` ← ~`d_s`.
  - Otherwise: `cnt` ← `cnt`+1.
- `busy` is high exactly when the state is CHECK.
- `rise`, `fall` and `glitch` are mutually exclusive and never high for two consecutive cycles from a single event.
- The counter never wraps, because a commit occurs at `STABLE`−1.
- Reset values: `q`=0, `rise`=0, `fall`=0, `glitch`=0, `busy`=0, `cnt`=0, state STABLE, synchronizer flops 0.
- Reset mid-count: the candidate is discarded with no `glitch` strobe. After release, counting restarts from STABLE.

## Timing
- Case: `d_s` first differs from `q` in cycle k and holds.
  - `busy` is high in cycles k+1 .. k+STABLE−1.
  - `q`, and `rise` or `fall`, change in cycle k+STABLE. Latency from `d` to `q` is `STABLE` cycles.
  - With `D_DEBOUNCE_SYNC_EN` the latency is `STABLE`+2 cycles.
- Case: the candidate reverts in cycle j, while in CHECK.
  - `glitch` is high in cycle j+1.
  - `busy` is low from cycle j+1.
- Revert exactly at the commit cycle: if `d_s` = `q` when `cnt` = `STABLE`−1, the revert wins. The result is `glitch` and no commit.
- Back-to-back transitions: a new opposite change detected in the cycle right after a commit starts a fresh count. The `rise`/`fall` strobe from the prior commit still fires.
- All outputs are registered, with no combinational path from `d` to any output.

## Configuration
- `D_DEBOUNCE_SYNC_EN` defined: a 2-flop synchronizer is inserted on `d`, reset to 0. This adds 2 cycles of latency. Use it when `d` is asynchronous to `clk`.
- `D_DEBOUNCE_SYNC_EN` undefined: `d` is used directly. The upstream `d_ff` must be clocked by `clk`.

## Test plan
- Clean rise. Setup: STABLE=4, reset released, `d`=0 for 5 cycles, then `d`=1 held. Required: `busy` high for 3 cycles, then `q`=1 and `rise`=1 for exactly 1 cycle, 4 cycles after the `d` change.
- Glitch rejection. Stimulus: with `q`=0, `d`=1 for 2 cycles, then 0. Required: `glitch`=1 for 1 cycle, `q` stays 0, no `rise`.
- Revert at the commit boundary. Stimulus: `d`=1 for exactly 3 cycles, then 0. Required: `glitch`=1, `q` stays 0. Also check that a 4-cycle pulse on `d` produces `rise`.
- Fall. Stimulus: from `q`=1, `d`=0 held. Required: `fall`=1 for 1 cycle and `q`=0, 4 cycles later.
- Reset mid-count. Stimulus: `d`=1, `rst` pulsed low for 1 cycle after 2 counted cycles. Required: all outputs 0 immediately, no `glitch`, and `rise` 4 cycles after `rst` returns high.
- `D_DEBOUNCE_SYNC_EN`. Repeat the clean-rise scenario. Required: `rise` 6 cycles after the `d` change.
